// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus bundle: incrementer link, instruction-memory request and
// response channels, redirect input and the decode-facing instruction port.
// The master side is the fetch sequencer; the slave side is its environment.
interface fetch_sequencer_if #(
  parameter int WIDTH = 30
);
  logic [WIDTH-1:0] increment_operand;
  logic [WIDTH-1:0] increment_result;
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [31:0]      imem_req_address;
  logic             imem_resp_valid;
  logic [31:0]      imem_resp_data;
  logic             redirect_valid;
  logic [31:0]      redirect_address;
  logic             inst_valid;
  logic             inst_ready;
  logic [31:0]      inst_data;
  logic [31:0]      inst_pc;

  modport master (
    output increment_operand,
    input  increment_result,
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_address,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  redirect_valid,
    input  redirect_address,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc
  );

  modport slave (
    input  increment_operand,
    output increment_result,
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_address,
    output imem_resp_valid,
    output imem_resp_data,
    output redirect_valid,
    output redirect_address,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch address stage. Holds the word fetch PC, issues in-order
// memory requests under a credit limit of DEPTH (in-flight + buffered),
// tracks in-flight requests with a kill flag so redirects can discard stale
// responses, and buffers returned instructions for decode.
module fetch_sequencer #(
  parameter int               WIDTH         = 30,
  parameter logic [WIDTH-1:0] RESET_ADDRESS = '0,
  parameter int               DEPTH         = 2
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.master  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : ptr_t'(p + 1'b1);
  endfunction

  // Fetch PC
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;

  // In-flight request FIFO: PC of each outstanding request plus kill flag
  logic [WIDTH-1:0] fl_pc_q [DEPTH];
  logic [DEPTH-1:0] fl_kill_q, fl_kill_d;
  ptr_t             fl_rd_q, fl_rd_d;
  ptr_t             fl_wr_q, fl_wr_d;
  cnt_t             fl_cnt_q, fl_cnt_d;

  // Instruction buffer feeding decode
  logic [31:0]      bf_data_q [DEPTH];
  logic [WIDTH-1:0] bf_pc_q   [DEPTH];
  ptr_t             bf_rd_q, bf_rd_d;
  ptr_t             bf_wr_q, bf_wr_d;
  cnt_t             bf_cnt_q, bf_cnt_d;

  logic          pop;
  logic [OW-1:0] occupancy;
  logic          credit;
  logic          req_valid;
  logic          req_fire;
  logic          resp_take;
  logic          resp_keep;
  logic          unused_addr_bits;

  // The low byte-offset bits of a redirect target are meaningless for word fetch
  assign unused_addr_bits = ^bus.redirect_address[1:0];

  // Handshake decode: credit check, request fire, response acceptance
  always_comb begin
    pop       = (bf_cnt_q != '0) && bus.inst_ready;
    occupancy = OW'(fl_cnt_q) + OW'(bf_cnt_q) - OW'(pop);
    credit    = occupancy < OW'(DEPTH);
    req_valid = !reset && !bus.redirect_valid && credit;
    req_fire  = req_valid && bus.imem_req_ready;
    // A response with nothing outstanding belongs to a pre-reset request
    resp_take = bus.imem_resp_valid && (fl_cnt_q != '0);
    resp_keep = resp_take && !fl_kill_q[fl_rd_q] && !bus.redirect_valid;
  end

  assign bus.increment_operand = fetch_pc_q;
  assign bus.imem_req_valid    = req_valid;
  assign bus.imem_req_address  = {fetch_pc_q, 2'b00};
  assign bus.inst_valid        = (bf_cnt_q != '0);
  assign bus.inst_data         = (bf_cnt_q != '0) ? bf_data_q[bf_rd_q] : '0;
  assign bus.inst_pc           = (bf_cnt_q != '0) ? {bf_pc_q[bf_rd_q], 2'b00} : '0;

  // Per-entry kill flag: a redirect kills everything outstanding, a new request starts live
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_kill
      assign fl_kill_d[gi] = bus.redirect_valid ? 1'b1 :
                             (req_fire && (fl_wr_q == ptr_t'(gi))) ? 1'b0 :
                             fl_kill_q[gi];
    end
  endgenerate

  // Next-state for fetch PC, in-flight pointers and instruction buffer pointers
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_address[31:2];
    end else if (req_fire) begin
      // Wraparound is the incrementer's job
      fetch_pc_d = bus.increment_result;
    end

    fl_rd_d  = resp_take ? ptr_inc(fl_rd_q) : fl_rd_q;
    fl_wr_d  = req_fire  ? ptr_inc(fl_wr_q) : fl_wr_q;
    fl_cnt_d = fl_cnt_q + cnt_t'(req_fire) - cnt_t'(resp_take);

    // A redirect flushes the buffer and cancels any pop in the same cycle
    bf_rd_d  = bf_rd_q;
    bf_wr_d  = bf_wr_q;
    bf_cnt_d = bf_cnt_q;
    if (bus.redirect_valid) begin
      bf_rd_d  = '0;
      bf_wr_d  = '0;
      bf_cnt_d = '0;
    end else begin
      if (resp_keep) bf_wr_d = ptr_inc(bf_wr_q);
      if (pop)       bf_rd_d = ptr_inc(bf_rd_q);
      bf_cnt_d = bf_cnt_q + cnt_t'(resp_keep) - cnt_t'(pop);
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_ADDRESS;
      fl_kill_q  <= '0;
      fl_rd_q    <= '0;
      fl_wr_q    <= '0;
      fl_cnt_q   <= '0;
      bf_rd_q    <= '0;
      bf_wr_q    <= '0;
      bf_cnt_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      fl_kill_q  <= fl_kill_d;
      fl_rd_q    <= fl_rd_d;
      fl_wr_q    <= fl_wr_d;
      fl_cnt_q   <= fl_cnt_d;
      bf_rd_q    <= bf_rd_d;
      bf_wr_q    <= bf_wr_d;
      bf_cnt_q   <= bf_cnt_d;
    end
  end

  // Payload storage; validity is tracked entirely by the counters above
  always_ff @(posedge clk) begin
    if (req_fire) begin
      fl_pc_q[fl_wr_q] <= fetch_pc_q;
    end
    if (resp_keep && !reset) begin
      bf_data_q[bf_wr_q] <= bus.imem_resp_data;
      bf_pc_q[bf_wr_q]   <= fl_pc_q[fl_rd_q];
    end
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch address stage of the core.
- Holds the 30-bit word fetch PC and drives it into the word incrementer (operand_1). It consumes the incrementer result as the sequential next PC.
- Issues in-order requests to instruction memory and buffers returned instructions for decode.
- Handles redirects (branch/jump/trap) and kills stale in-flight responses.

Parameters:
WIDTH, 30, word-address width; byte address = {word, 2'b00}
RESET_ADDRESS, 30'h0000_0000, word address loaded on reset
DEPTH, 2, max (in-flight requests + buffered instructions)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high
increment_operand  output  WIDTH  current fetch word PC; to incrementer operand_1
increment_result  input  WIDTH  incrementer result, operand+1 mod 2^WIDTH
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_address  output  32  byte address {fetch_pc, 2'b00}
imem_resp_valid  input  1  response valid; in order; no backpressure
imem_resp_data  input  32  instruction word
redirect_valid  input  1  one-cycle redirect pulse
redirect_address  input  32  new byte PC; bits [1:0] ignored
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode accepts
inst_data  output  32  instruction at buffer head; 0 when inst_valid=0
inst_pc  output  32  byte PC of inst_data; 0 when inst_valid=0

Behaviour:
- Reset (sync, high):
  - fetch_pc=RESET_ADDRESS; in-flight FIFO empty; instruction buffer empty.
  - imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
  - Reset mid-operation discards everything. Responses arriving during reset or afterwards for pre-reset requests are ignored: in-flight count is 0.
- Increment path:
  - increment_operand = fetch_pc, combinational.
  - On request handshake (imem_req_valid & imem_req_ready), fetch_pc <= increment_result.
  - Wrap 30'h3FFFFFFF -> 0 comes from the incrementer; no special case here.
- Credit rule:
  - imem_req_valid = !reset & !redirect_valid & (inflight + buffered - pop < DEPTH), where pop = inst_valid & inst_ready.
  - Responses can never overflow the buffer.
- Request stability: while imem_req_valid & !imem_req_ready, the address stays stable. Only a redirect may withdraw or change it.
- In-flight FIFO (DEPTH entries):
  - Each handshake pushes {fetch_pc, kill=0}.
  - Each imem_resp_valid pops the head.
  - If kill=0, push {data, pc} into the instruction buffer. If kill=1, drop the response.
  - imem_resp_valid with empty in-flight FIFO: ignored; no state change.
- Instruction buffer (DEPTH-entry FIFO):
  - inst_valid = not empty.
  - Pop on inst_valid & inst_ready.
  - Response-to-inst_valid latency: 1 cycle (registered).
  - Push and pop in the same cycle are both honoured.
- Redirect (priority over everything except reset):
  - fetch_pc <= redirect_address[31:2].
  - Instruction buffer flushed.
  - All current in-flight entries set kill=1; they still count toward credit until their responses return.
  - A response arriving in the redirect cycle is dropped.
  - A pop in the redirect cycle has no effect.
  - No request is issued in the redirect cycle.
  - Back-to-back redirects: the last one wins; all earlier in-flight entries stay killed.
- Throughput: with a 1-cycle memory and inst_ready=1, one instruction per cycle sustained.
  - The first request after reset deasserts is issued in that cycle.
  - The first inst_valid appears 2 cycles after that request handshake.

Test Plan:
- Reset, RESET_ADDRESS=0, memory always ready, 1-cycle response, inst_ready=1 -> imem_req_address 0x0,0x4,0x8,... one per cycle; inst_pc matches each address; inst_valid first high 2 cycles after the first handshake.
- inst_ready=0 for 6 cycles -> exactly 2 instructions buffered; imem_req_valid=0 once inflight+buffered=2; inst_pc/inst_data held at 0x0 entry; no loss on release.
- Two requests in flight (0x100, 0x104), redirect to 0x2000 -> both responses dropped; next inst_pc=0x2000, then 0x2004; no 0x100/0x104 visible.
- fetch_pc=30'h3FFFFFFF -> imem_req_address 0xFFFFFFFC, then 0x00000000.
- imem_req_ready=0 for 4 cycles -> imem_req_address held constant; redirect_address 0x0000_0043 in that window -> next request 0x40.
- Assert reset with 2 in flight and 1 buffered, then return the 2 responses after reset -> inst_valid stays 0; fetch restarts at RESET_ADDRESS.
